bin_count_gen: RTL and testbench

//   Binary sequence source that sits directly upstream of the binary-to-Gray

---
 rtl/bin_count_gen.sv | 111 +++++++++++
 tb/tb_bin_count_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_count_gen.sv
// rtl/bin_count_gen.sv - up/down modulo binary counter with load and valid/ready output
// Optional SATURATE_EN: saturating count with level terminal-count flag.
module bin_count_gen #(
   parameter int WIDTH   = 4,
   parameter int MAX_VAL = (1 << WIDTH) - 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             load_ack,
   output logic [WIDTH-1:0] bin_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             tc
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] STALL = 2'd2;

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

   logic [1:0]       state, state_d;
   logic [WIDTH-1:0] bin_d, nxt, ld_val;
   logic             valid_d, ack_d, tc_d, wrapped;
   logic             free, xfer, load_acc;

   assign free     = !out_valid || out_ready;
   assign xfer     = out_valid && out_ready;
   assign load_acc = load && free;
   assign ld_val   = (load_val > MAXV) ? MAXV : load_val;

   // next() of the presented value; at a limit it either wraps or holds
   always_comb begin
      nxt     = bin_out;
      wrapped = 1'b0;
      if (up_dn) begin
         if (bin_out >= MAXV) begin
`ifdef SATURATE_EN
            nxt = MAXV;
`else
            nxt     = '0;
            wrapped = 1'b1;
`endif
         end else begin
            nxt = bin_out + WIDTH'(1);
         end
      end else begin
         if (bin_out == '0) begin
`ifdef SATURATE_EN
            nxt = '0;
`else
            nxt     = MAXV;
            wrapped = 1'b1;
`endif
         end else begin
            nxt = bin_out - WIDTH'(1);
         end
      end
   end

   always_comb begin
      bin_d   = bin_out;
      valid_d = out_valid;
      state_d = state;
      ack_d   = 1'b0;
      // load wins over both a simultaneous advance and en=0
      if (load_acc) begin
         bin_d   = ld_val;
         valid_d = 1'b1;
         state_d = RUN;
         ack_d   = 1'b1;
      end else if (xfer) begin
         bin_d   = nxt;
         valid_d = en;
         state_d = en ? RUN : IDLE;
      end else if (!out_valid) begin
         if (en) begin
            valid_d = 1'b1;
            state_d = RUN;
         end
      end else begin
         state_d = STALL;
      end
`ifdef SATURATE_EN
      tc_d = up_dn ? (bin_d == MAXV) : (bin_d == '0);
`else
      tc_d = xfer && !load_acc && wrapped;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bin_out   <= '0;
         out_valid <= 1'b0;
         load_ack  <= 1'b0;
         tc        <= 1'b0;
      end else begin
         state     <= state_d;
         bin_out   <= bin_d;
         out_valid <= valid_d;
         load_ack  <= ack_d;
         tc        <= tc_d;
      end
   end

endmodule

// File: tb/tb_bin_count_gen.sv
// tb/tb_bin_count_gen.sv - directed bench for bin_count_gen (MAX_VAL 15 and 9 instances)
module tb_bin_count_gen;

`ifdef SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, up_dn = 1'b1, load = 1'b0, out_ready = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic       load_ack, out_valid, tc;
   logic [3:0] bin_out;

   logic       e9 = 1'b0, u9 = 1'b1, l9 = 1'b0, r9 = 1'b0;
   logic [3:0] lv9 = 4'd0;
   logic       a9, v9, t9;
   logic [3:0] b9;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   bin_count_gen #(.WIDTH(4), .MAX_VAL(15)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .load_ack(load_ack), .bin_out(bin_out),
      .out_valid(out_valid), .out_ready(out_ready), .tc(tc)
   );

   bin_count_gen #(.WIDTH(4), .MAX_VAL(9)) dut9 (
      .clk(clk), .rst_n(rst_n), .en(e9), .up_dn(u9), .load(l9),
      .load_val(lv9), .load_ack(a9), .bin_out(b9),
      .out_valid(v9), .out_ready(r9), .tc(t9)
   );

   task automatic test_reset;
      repeat (2) @(negedge clk);
      total++;
      if ({bin_out, out_valid, load_ack, tc} !== 7'b0) begin
         bad++;
         $display("FAIL reset: got bin=%0d v=%0b ack=%0b tc=%0b, want all 0", bin_out, out_valid, load_ack, tc);
      end
      total++;
      if ({b9, v9, a9, t9} !== 7'b0) begin
         bad++;
         $display("FAIL reset9: got bin=%0d v=%0b ack=%0b tc=%0b, want all 0", b9, v9, a9, t9);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_count_up;
      logic [3:0] eb;
      logic       et;
      en = 1'b1; up_dn = 1'b1; out_ready = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         @(negedge clk);
         eb = SAT ? ((i > 15) ? 4'd15 : 4'(i)) : 4'(i % 16);
         et = SAT ? (eb == 4'd15) : (i == 16);
         total++;
         if (bin_out !== eb || out_valid !== 1'b1 || tc !== et) begin
            bad++;
            $display("FAIL count_up[%0d]: got bin=%0d v=%0b tc=%0b, want bin=%0d v=1 tc=%0b", i, bin_out, out_valid, tc, eb, et);
         end
      end
   endtask

   task automatic test_stall;
      load = 1'b1; load_val = 4'd1;
      @(negedge clk);
      load = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (bin_out !== 4'd3) begin
         bad++;
         $display("FAIL stall_pre: got bin=%0d, want 3", bin_out);
      end
      out_ready = 1'b0;
      up_dn = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (bin_out !== 4'd3 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall_hold[%0d]: got bin=%0d v=%0b, want bin=3 v=1", i, bin_out, out_valid);
         end
      end
      up_dn = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (bin_out !== 4'd4) begin
         bad++;
         $display("FAIL stall_release: got bin=%0d, want 4", bin_out);
      end
   endtask

   task automatic test_load_down;
      load = 1'b1; load_val = 4'd0; up_dn = 1'b0;
      @(negedge clk);
      load = 1'b0;
      total++;
      if (bin_out !== 4'd0 || load_ack !== 1'b1 || tc !== SAT) begin
         bad++;
         $display("FAIL load0: got bin=%0d ack=%0b tc=%0b, want bin=0 ack=1 tc=%0b", bin_out, load_ack, tc, SAT);
      end
      @(negedge clk);
      total++;
      if (bin_out !== (SAT ? 4'd0 : 4'd15) || load_ack !== 1'b0 || tc !== 1'b1) begin
         bad++;
         $display("FAIL down_wrap: got bin=%0d ack=%0b tc=%0b, want bin=%0d ack=0 tc=1", bin_out, load_ack, tc, SAT ? 0 : 15);
      end
   endtask

   task automatic test_load_stalled;
      load = 1'b1; load_val = 4'd5; up_dn = 1'b1;
      @(negedge clk);
      load = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      load = 1'b1; load_val = 4'd7;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (bin_out !== 4'd5 || load_ack !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL load_ignored[%0d]: got bin=%0d ack=%0b v=%0b, want bin=5 ack=0 v=1", i, bin_out, load_ack, out_valid);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      load = 1'b0;
      total++;
      if (bin_out !== 4'd7 || load_ack !== 1'b1) begin
         bad++;
         $display("FAIL load_after_stall: got bin=%0d ack=%0b, want bin=7 ack=1", bin_out, load_ack);
      end
      @(negedge clk);
      total++;
      if (bin_out !== 4'd8 || load_ack !== 1'b0) begin
         bad++;
         $display("FAIL after_load: got bin=%0d ack=%0b, want bin=8 ack=0", bin_out, load_ack);
      end
   endtask

   task automatic test_en_drop;
      en = 1'b0;
      @(negedge clk);
      total++;
      if (bin_out !== 4'd9 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL en_drop: got bin=%0d v=%0b, want bin=9 v=0", bin_out, out_valid);
      end
      @(negedge clk);
      total++;
      if (bin_out !== 4'd9 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_hold: got bin=%0d v=%0b, want bin=9 v=0", bin_out, out_valid);
      end
      en = 1'b1;
      @(negedge clk);
      total++;
      if (bin_out !== 4'd9 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL idle_to_run: got bin=%0d v=%0b, want bin=9 v=1", bin_out, out_valid);
      end
   endtask

   task automatic test_async_reset;
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({bin_out, out_valid, load_ack, tc} !== 7'b0) begin
         bad++;
         $display("FAIL async_reset: got bin=%0d v=%0b ack=%0b tc=%0b, want all 0", bin_out, out_valid, load_ack, tc);
      end
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_clamp9;
      logic [3:0] eb [0:3];
      logic       et [0:3];
      if (SAT) begin
         eb = '{4'd9, 4'd9, 4'd9, 4'd8};
         et = '{1'b1, 1'b1, 1'b1, 1'b0};
      end else begin
         eb = '{4'd9, 4'd0, 4'd1, 4'd0};
         et = '{1'b0, 1'b1, 1'b0, 1'b0};
      end
      e9 = 1'b1; u9 = 1'b1; r9 = 1'b1; l9 = 1'b1; lv9 = 4'd12;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         l9 = 1'b0;
         if (i == 2) u9 = 1'b0;
         total++;
         if (b9 !== eb[i] || t9 !== et[i] || a9 !== (i == 0)) begin
            bad++;
            $display("FAIL clamp9[%0d]: got bin=%0d tc=%0b ack=%0b, want bin=%0d tc=%0b ack=%0b", i, b9, t9, a9, eb[i], et[i], i == 0);
         end
      end
   endtask

   initial begin
      test_reset;
      test_count_up;
      test_stall;
      test_load_down;
      test_load_stalled;
      test_en_drop;
      test_async_reset;
      test_clamp9;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
